// File: rtl/icache_assoc.sv
// Set-associative (1- or 2-way) instruction cache with LRU replacement.
// It fetches a whole line word by word from memory on a miss and never writes data back.
module icache_assoc #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        pcRST,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int OFFW = $clog2(BLKWORDS);
  localparam int OFFS = (OFFW == 0) ? 1 : OFFW;
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 30 - OFFW - IDXW;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_FILL = 2'd2} state_t;

  state_t            r_state;
  logic [OFFS-1:0]   r_cnt;
  logic [31:0]       r_base;
  logic [31:0]       r_buf   [BLKWORDS];
  logic              r_valid [WAYS][SETS];
  logic [TAGW-1:0]   r_tag   [WAYS][SETS];
  logic [31:0]       r_data  [WAYS][SETS][BLKWORDS];
  // r_lru names the least recently used way of each set
  logic              r_lru   [SETS];

  logic [29:0]       w_word;
  logic [OFFS-1:0]   w_off;
  logic [IDXW-1:0]   w_idx;
  logic [TAGW-1:0]   w_tag;
  logic [IDXW-1:0]   w_fidx;
  logic [TAGW-1:0]   w_ftag;
  logic              w_match;
  logic              w_hit_way;
  logic [31:0]       w_hit_data;
  logic              w_victim;
  logic              w_unused;

  assign w_word   = imemaddr[31:2];
  assign w_off    = OFFS'(w_word & 30'(BLKWORDS - 1));
  assign w_idx    = IDXW'(w_word >> OFFW);
  assign w_tag    = imemaddr[31 -: TAGW];
  assign w_fidx   = IDXW'(r_base[31:2] >> OFFW);
  assign w_ftag   = r_base[31 -: TAGW];
  assign w_unused = &{1'b0, imemaddr[1:0]};

  // Tag compare across ways; the lowest matching way wins.
  always_comb begin
    w_match    = 1'b0;
    w_hit_way  = 1'b0;
    w_hit_data = 32'h0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag) && !w_match) begin
        w_match    = 1'b1;
        w_hit_way  = 1'(w);
        w_hit_data = r_data[w][w_idx][w_off];
      end else begin
        w_match    = w_match;
      end
    end
  end

  // Victim for the line being filled: first invalid way, otherwise LRU.
  always_comb begin
    w_victim = 1'b0;
    if (WAYS == 1) begin
      w_victim = 1'b0;
    end else if (!r_valid[0][w_fidx]) begin
      w_victim = 1'b0;
    end else if (!r_valid[WAYS-1][w_fidx]) begin
      w_victim = 1'b1;
    end else begin
      w_victim = r_lru[w_fidx];
    end
  end

  assign ihit     = imemREN && !pcRST && w_match;
  assign imemload = ihit ? w_hit_data : 32'h0;
  assign iREN     = (r_state == S_FETCH);
  assign iaddr    = iREN ? (r_base + (32'(r_cnt) << 2)) : 32'h0;

  // Miss FSM, line buffer, tag/data arrays and LRU state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_base  <= 32'h0;
      for (int b = 0; b < BLKWORDS; b++) r_buf[b] <= 32'h0;
      for (int s = 0; s < SETS; s++) begin
        r_lru[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[w][s] <= 1'b0;
          r_tag[w][s]   <= '0;
          for (int b = 0; b < BLKWORDS; b++) r_data[w][s][b] <= 32'h0;
        end
      end
    end else begin
      if (ihit && (WAYS == 2)) begin
        r_lru[w_idx] <= ~w_hit_way;
      end else begin
        r_lru[w_idx] <= r_lru[w_idx];
      end
      case (r_state)
        S_IDLE: begin
          if (imemREN && !pcRST && !w_match) begin
            r_base  <= imemaddr & ~32'(BLKWORDS * 4 - 1);
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FETCH: begin
          // A flush abandons the line; the buffer is simply overwritten next time.
          if (pcRST) begin
            r_state <= S_IDLE;
          end else if (!iwait) begin
            r_buf[r_cnt] <= iload;
            if (r_cnt == OFFS'(BLKWORDS - 1)) begin
              r_state <= S_FILL;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_FILL: begin
          r_valid[w_victim][w_fidx] <= 1'b1;
          r_tag[w_victim][w_fidx]   <= w_ftag;
          for (int b = 0; b < BLKWORDS; b++) r_data[w_victim][w_fidx][b] <= r_buf[b];
          if (WAYS == 2) begin
            r_lru[w_fidx] <= ~w_victim;
          end else begin
            r_lru[w_fidx] <= 1'b0;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Randomized self-checking bench for icache_assoc (8 sets, 2 ways, 2-word lines)
// against a per-set MRU-ordered tag list model.
module tb_icache_assoc;

  logic        CLK, nRST, imemREN, pcRST, ihit, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload;
  int n_err = 0;
  int n_chk = 0;
  int wait_n = 0;
  int wcnt = 0;
  int m_tag [8][2];
  int m_cnt [8];

  icache_assoc #(.SETS(8), .WAYS(2), .BLKWORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .pcRST(pcRST),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hAAAA0000 | {16'h0, a[15:0]};
  endfunction

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign iload = mem(iaddr);
  assign iwait = iREN && (wcnt < wait_n);
  always @(posedge CLK) begin
    if (iREN && iwait) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_lookup(input logic [31:0] a);
    int s = int'(a[5:3]);
    int t = int'(a[31:6]);
    for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_touch(input logic [31:0] a);
    int s = int'(a[5:3]);
    int t = int'(a[31:6]);
    if (m_cnt[s] == 2 && m_tag[s][1] == t) begin
      m_tag[s][1] = m_tag[s][0];
      m_tag[s][0] = t;
    end
  endtask

  task automatic m_fill(input logic [31:0] a);
    int s = int'(a[5:3]);
    m_tag[s][1] = m_tag[s][0];
    m_tag[s][0] = int'(a[31:6]);
    if (m_cnt[s] < 2) m_cnt[s]++;
  endtask

  task automatic m_reset();
    for (int s = 0; s < 8; s++) m_cnt[s] = 0;
  endtask

  task automatic access(input logic [31:0] a);
    logic [31:0] base;
    int k, n;
    bit acc, done;
    base = a & ~32'h7;
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = a;
    @(negedge CLK);
    if (m_lookup(a)) begin
      chk("hit", 32'(ihit), 32'h1);
      chk("hit_data", imemload, mem(a));
      m_touch(a);
    end else begin
      chk("miss_ihit", 32'(ihit), 32'h0);
      chk("miss_load", imemload, 32'h0);
      k = 0; n = 0; done = 1'b0;
      while (!done && n < 100) begin
        acc = iREN && !iwait;
        @(posedge CLK);
        if (acc) k++;
        n++;
        @(negedge CLK);
        if (ihit) done = 1'b1;
        else if (iREN) chk("iaddr", iaddr, base + 32'(4 * k));
      end
      chk("fill_done", 32'(done), 32'h1);
      chk("latency", 32'(n), 32'(2 * (wait_n + 1) + 2));
      chk("words", 32'(k), 32'h2);
      chk("fill_data", imemload, mem(a));
      chk("iren_after", 32'(iREN), 32'h0);
      m_fill(a);
    end
  endtask

  task automatic probe(input logic [31:0] a);
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = a;
    @(negedge CLK);
    chk("probe_ihit", 32'(ihit), 32'(m_lookup(a)));
    #1 imemREN = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    nRST = 1'b0; pcRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40;
    #3;
    chk("rst_ihit", 32'(ihit), 32'h0);
    chk("rst_load", imemload, 32'h0);
    chk("rst_iren", 32'(iREN), 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    imemREN = 1'b0;
    #9 nRST = 1'b1;

    // cold miss, same-line hit, two-way fill, LRU eviction
    access(32'h40);
    access(32'h44);
    access(32'h80);
    access(32'h40);
    access(32'h80);
    access(32'h40);
    access(32'hC0);
    probe(32'h80);
    access(32'h44);
    // wait states
    wait_n = 3;
    access(32'h100);
    wait_n = 0;

    // asynchronous reset mid-fetch
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'h180; wait_n = 3;
    @(posedge CLK); #2;
    chk("pre_rst_iren", 32'(iREN), 32'h1);
    nRST = 1'b0;
    #1;
    chk("arst_iren", 32'(iREN), 32'h0);
    chk("arst_iaddr", iaddr, 32'h0);
    chk("arst_ihit", 32'(ihit), 32'h0);
    imemREN = 1'b0; wait_n = 0;
    m_reset();
    @(negedge CLK); #2 nRST = 1'b1;
    probe(32'h40);
    probe(32'hC0);
    probe(32'h180);

    // flush after the first word
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'h40;
    @(posedge CLK);
    @(posedge CLK); #1;
    pcRST = 1'b1;
    @(negedge CLK);
    chk("flush_ihit", 32'(ihit), 32'h0);
    chk("flush_iren_now", 32'(iREN), 32'h1);
    @(negedge CLK);
    chk("flush_iren_next", 32'(iREN), 32'h0);
    chk("flush_iaddr_next", iaddr, 32'h0);
    #1 pcRST = 1'b0; imemREN = 1'b0;
    access(32'h40);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      wait_n = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge CLK); #1;
        imemREN = 1'b0;
        @(negedge CLK);
        chk("idle_ihit", 32'(ihit), 32'h0);
        chk("idle_load", imemload, 32'h0);
        chk("idle_iren", 32'(iREN), 32'h0);
      end else begin
        access(32'($urandom_range(0, 63)) * 32'h4);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
